mem_burst_arbiter: RTL and testbench

Two-client arbiter sharing the single PL burst port (read/write request, length, address, data handshakes) of the PS DDR AXI master adapter. Each client sees a private copy of the same burst interface the memory test generator drives. The arbiter grants one whole burst at a time, round-robin between clients, and routes data handshakes and finish pulses only to the granted client. It sits between traffic generators (e.g. memory test, frame writer) and the AXI burst adapter.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_burst_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-client burst arbiter.
//   arb_state_e : arbiter FSM states
//   DIR_RD/DIR_WR : direction encoding of a latched grant
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    ZERO    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational source picker.
//   req          in  {c1_wr, c1_rd, c0_wr, c0_rd} request bits
//   last_client  in  client that owned the most recent completed grant
//   pick_valid   out at least one request is present
//   pick_client  out chosen client (round-robin on tie)
//   pick_dir     out chosen direction (write wins within a client)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic       last_client,
  output logic       pick_valid,
  output logic       pick_client,
  output logic       pick_dir
);

  logic c0_any;
  logic c1_any;

  assign c0_any     = req[0] | req[1];
  assign c1_any     = req[2] | req[3];
  assign pick_valid = c0_any | c1_any;

  always_comb begin
    pick_client = 1'b0;
    if (c0_any && c1_any) begin
      pick_client = ~last_client;
    end else if (c1_any) begin
      pick_client = 1'b1;
    end
  end

  always_comb begin
    pick_dir = DIR_RD;
    if (pick_client ? req[3] : req[1]) begin
      pick_dir = DIR_WR;
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares one burst port between two clients.
//   mem_clk, rst_n          clock, async active-low reset
//   cK_* (K = 0, 1)         per-client burst interface (req/len/addr/data in,
//                           data handshakes and finish pulses out)
//   m_*                     single burst port towards the AXI adapter
//   busy                    a grant is active (BURST, ZERO, RELEASE)
//   grant_client            owner of the current or last grant
//   grant_write             current grant is a write
// One whole burst is granted at a time; request, length and address are
// latched at grant so a client cannot disturb a burst in flight.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned LEN_BITS      = 10
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,

  input  logic                     c0_rd_burst_req,
  input  logic                     c0_wr_burst_req,
  input  logic [LEN_BITS-1:0]      c0_rd_burst_len,
  input  logic [LEN_BITS-1:0]      c0_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     c0_rd_burst_addr,
  input  logic [ADDR_BITS-1:0]     c0_wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_burst_data,
  output logic [MEM_DATA_BITS-1:0] c0_rd_burst_data,
  output logic                     c0_rd_burst_data_valid,
  output logic                     c0_wr_burst_data_req,
  output logic                     c0_rd_burst_finish,
  output logic                     c0_wr_burst_finish,

  input  logic                     c1_rd_burst_req,
  input  logic                     c1_wr_burst_req,
  input  logic [LEN_BITS-1:0]      c1_rd_burst_len,
  input  logic [LEN_BITS-1:0]      c1_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     c1_rd_burst_addr,
  input  logic [ADDR_BITS-1:0]     c1_wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_burst_data,
  output logic [MEM_DATA_BITS-1:0] c1_rd_burst_data,
  output logic                     c1_rd_burst_data_valid,
  output logic                     c1_wr_burst_data_req,
  output logic                     c1_rd_burst_finish,
  output logic                     c1_wr_burst_finish,

  output logic                     m_rd_burst_req,
  output logic                     m_wr_burst_req,
  output logic [LEN_BITS-1:0]      m_rd_burst_len,
  output logic [LEN_BITS-1:0]      m_wr_burst_len,
  output logic [ADDR_BITS-1:0]     m_rd_burst_addr,
  output logic [ADDR_BITS-1:0]     m_wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] m_wr_burst_data,
  input  logic [MEM_DATA_BITS-1:0] m_rd_burst_data,
  input  logic                     m_rd_burst_data_valid,
  input  logic                     m_wr_burst_data_req,
  input  logic                     m_rd_burst_finish,
  input  logic                     m_wr_burst_finish,

  output logic                     busy,
  output logic                     grant_client,
  output logic                     grant_write
);

  arb_state_e           state_q, state_d;
  logic                 cli_q, cli_d;
  logic                 dir_q, dir_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_req_q, rd_req_d;
  logic                 wr_req_q, wr_req_d;
  logic                 last_q, last_d;

  logic                 pick_valid;
  logic                 pick_client;
  logic                 pick_dir;
  logic [LEN_BITS-1:0]  sel_len;
  logic [ADDR_BITS-1:0] sel_addr;

  logic                 in_burst;
  logic                 m_fin_sel;
  logic                 fin_pulse;

  mem_arb_pick u_pick (
    .req         ({c1_wr_burst_req, c1_rd_burst_req, c0_wr_burst_req, c0_rd_burst_req}),
    .last_client (last_q),
    .pick_valid  (pick_valid),
    .pick_client (pick_client),
    .pick_dir    (pick_dir)
  );

  always_comb begin
    sel_len  = c0_rd_burst_len;
    sel_addr = c0_rd_burst_addr;
    unique case ({pick_client, pick_dir})
      {1'b0, DIR_RD}: begin
        sel_len  = c0_rd_burst_len;
        sel_addr = c0_rd_burst_addr;
      end
      {1'b0, DIR_WR}: begin
        sel_len  = c0_wr_burst_len;
        sel_addr = c0_wr_burst_addr;
      end
      {1'b1, DIR_RD}: begin
        sel_len  = c1_rd_burst_len;
        sel_addr = c1_rd_burst_addr;
      end
      {1'b1, DIR_WR}: begin
        sel_len  = c1_wr_burst_len;
        sel_addr = c1_wr_burst_addr;
      end
      default: ;
    endcase
  end

  assign in_burst = (state_q == BURST);
  // Only the finish matching the granted direction ends a burst.
  assign m_fin_sel = in_burst &&
                     ((dir_q == DIR_WR) ? m_wr_burst_finish : m_rd_burst_finish);
  assign fin_pulse = m_fin_sel || (state_q == ZERO);

  always_comb begin
    state_d  = state_q;
    cli_d    = cli_q;
    dir_d    = dir_q;
    len_d    = len_q;
    addr_d   = addr_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cli_d  = pick_client;
          dir_d  = pick_dir;
          len_d  = sel_len;
          addr_d = sel_addr;
          if (sel_len == '0) begin
            state_d = ZERO;
          end else begin
            state_d = BURST;
            if (pick_dir == DIR_WR) begin
              wr_req_d = 1'b1;
            end else begin
              rd_req_d = 1'b1;
            end
          end
        end
      end
      BURST: begin
        if (m_fin_sel) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          last_d   = cli_q;
          state_d  = RELEASE;
        end
      end
      ZERO: begin
        last_d  = cli_q;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Gives the client a cycle to drop its request after the finish.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cli_q    <= 1'b0;
      dir_q    <= DIR_RD;
      len_q    <= '0;
      addr_q   <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      last_q   <= 1'b1;  // client 0 wins the first tie
    end else begin
      state_q  <= state_d;
      cli_q    <= cli_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      last_q   <= last_d;
    end
  end

  // Master side: length/address only shown while the matching request is up.
  assign m_rd_burst_req  = rd_req_q;
  assign m_wr_burst_req  = wr_req_q;
  assign m_rd_burst_len  = rd_req_q ? len_q : '0;
  assign m_wr_burst_len  = wr_req_q ? len_q : '0;
  assign m_rd_burst_addr = rd_req_q ? addr_q : '0;
  assign m_wr_burst_addr = wr_req_q ? addr_q : '0;
  assign m_wr_burst_data = cli_q ? c1_wr_burst_data : c0_wr_burst_data;

  assign c0_rd_burst_data = m_rd_burst_data;
  assign c1_rd_burst_data = m_rd_burst_data;

  assign c0_rd_burst_data_valid = in_burst && !cli_q && (dir_q == DIR_RD) && m_rd_burst_data_valid;
  assign c1_rd_burst_data_valid = in_burst &&  cli_q && (dir_q == DIR_RD) && m_rd_burst_data_valid;
  assign c0_wr_burst_data_req   = in_burst && !cli_q && (dir_q == DIR_WR) && m_wr_burst_data_req;
  assign c1_wr_burst_data_req   = in_burst &&  cli_q && (dir_q == DIR_WR) && m_wr_burst_data_req;

  assign c0_rd_burst_finish = fin_pulse && !cli_q && (dir_q == DIR_RD);
  assign c1_rd_burst_finish = fin_pulse &&  cli_q && (dir_q == DIR_RD);
  assign c0_wr_burst_finish = fin_pulse && !cli_q && (dir_q == DIR_WR);
  assign c1_wr_burst_finish = fin_pulse &&  cli_q && (dir_q == DIR_WR);

  assign busy         = (state_q != IDLE);
  assign grant_client = cli_q;
  assign grant_write  = busy && (dir_q == DIR_WR);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; the adapter side is driven by hand.
module tb_mem_burst_arbiter;

  logic        mem_clk;
  logic        rst_n;

  logic        c0_rd_burst_req, c0_wr_burst_req;
  logic [9:0]  c0_rd_burst_len, c0_wr_burst_len;
  logic [31:0] c0_rd_burst_addr, c0_wr_burst_addr;
  logic [63:0] c0_wr_burst_data, c0_rd_burst_data;
  logic        c0_rd_burst_data_valid, c0_wr_burst_data_req;
  logic        c0_rd_burst_finish, c0_wr_burst_finish;

  logic        c1_rd_burst_req, c1_wr_burst_req;
  logic [9:0]  c1_rd_burst_len, c1_wr_burst_len;
  logic [31:0] c1_rd_burst_addr, c1_wr_burst_addr;
  logic [63:0] c1_wr_burst_data, c1_rd_burst_data;
  logic        c1_rd_burst_data_valid, c1_wr_burst_data_req;
  logic        c1_rd_burst_finish, c1_wr_burst_finish;

  logic        m_rd_burst_req, m_wr_burst_req;
  logic [9:0]  m_rd_burst_len, m_wr_burst_len;
  logic [31:0] m_rd_burst_addr, m_wr_burst_addr;
  logic [63:0] m_wr_burst_data, m_rd_burst_data;
  logic        m_rd_burst_data_valid, m_wr_burst_data_req;
  logic        m_rd_burst_finish, m_wr_burst_finish;

  logic        busy, grant_client, grant_write;

  int errors = 0;
  int checks = 0;
  int cnt0;
  int cnt1;

  mem_burst_arbiter #(
    .MEM_DATA_BITS (64),
    .ADDR_BITS     (32),
    .LEN_BITS      (10)
  ) dut (
    .mem_clk                (mem_clk),
    .rst_n                  (rst_n),
    .c0_rd_burst_req        (c0_rd_burst_req),
    .c0_wr_burst_req        (c0_wr_burst_req),
    .c0_rd_burst_len        (c0_rd_burst_len),
    .c0_wr_burst_len        (c0_wr_burst_len),
    .c0_rd_burst_addr       (c0_rd_burst_addr),
    .c0_wr_burst_addr       (c0_wr_burst_addr),
    .c0_wr_burst_data       (c0_wr_burst_data),
    .c0_rd_burst_data       (c0_rd_burst_data),
    .c0_rd_burst_data_valid (c0_rd_burst_data_valid),
    .c0_wr_burst_data_req   (c0_wr_burst_data_req),
    .c0_rd_burst_finish     (c0_rd_burst_finish),
    .c0_wr_burst_finish     (c0_wr_burst_finish),
    .c1_rd_burst_req        (c1_rd_burst_req),
    .c1_wr_burst_req        (c1_wr_burst_req),
    .c1_rd_burst_len        (c1_rd_burst_len),
    .c1_wr_burst_len        (c1_wr_burst_len),
    .c1_rd_burst_addr       (c1_rd_burst_addr),
    .c1_wr_burst_addr       (c1_wr_burst_addr),
    .c1_wr_burst_data       (c1_wr_burst_data),
    .c1_rd_burst_data       (c1_rd_burst_data),
    .c1_rd_burst_data_valid (c1_rd_burst_data_valid),
    .c1_wr_burst_data_req   (c1_wr_burst_data_req),
    .c1_rd_burst_finish     (c1_rd_burst_finish),
    .c1_wr_burst_finish     (c1_wr_burst_finish),
    .m_rd_burst_req         (m_rd_burst_req),
    .m_wr_burst_req         (m_wr_burst_req),
    .m_rd_burst_len         (m_rd_burst_len),
    .m_wr_burst_len         (m_wr_burst_len),
    .m_rd_burst_addr        (m_rd_burst_addr),
    .m_wr_burst_addr        (m_wr_burst_addr),
    .m_wr_burst_data        (m_wr_burst_data),
    .m_rd_burst_data        (m_rd_burst_data),
    .m_rd_burst_data_valid  (m_rd_burst_data_valid),
    .m_wr_burst_data_req    (m_wr_burst_data_req),
    .m_rd_burst_finish      (m_rd_burst_finish),
    .m_wr_burst_finish      (m_wr_burst_finish),
    .busy                   (busy),
    .grant_client           (grant_client),
    .grant_write            (grant_write)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    c0_rd_burst_req = 0; c0_wr_burst_req = 0;
    c0_rd_burst_len = '0; c0_wr_burst_len = '0;
    c0_rd_burst_addr = '0; c0_wr_burst_addr = '0;
    c0_wr_burst_data = 64'hC0C0_0000_0000_00A5;
    c1_rd_burst_req = 0; c1_wr_burst_req = 0;
    c1_rd_burst_len = '0; c1_wr_burst_len = '0;
    c1_rd_burst_addr = '0; c1_wr_burst_addr = '0;
    c1_wr_burst_data = 64'hC1C1_0000_0000_005A;
    m_rd_burst_data = 64'h0; m_rd_burst_data_valid = 0;
    m_wr_burst_data_req = 0; m_rd_burst_finish = 0; m_wr_burst_finish = 0;

    // ---- reset state ----
    tick(); tick();
    check("rst_m_wr_req", 64'(m_wr_burst_req), 64'd0);
    check("rst_m_rd_req", 64'(m_rd_burst_req), 64'd0);
    check("rst_m_wr_addr", 64'(m_wr_burst_addr), 64'd0);
    check("rst_m_rd_len", 64'(m_rd_burst_len), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_client", 64'(grant_client), 64'd0);
    check("rst_grant_write", 64'(grant_write), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- c0 write, len 128, address held against mid-burst change ----
    c0_wr_burst_req = 1; c0_wr_burst_len = 10'd128; c0_wr_burst_addr = 32'h0200_0000;
    #1;
    check("t1_req_not_yet", 64'(m_wr_burst_req), 64'd0);
    tick();
    check("t1_m_wr_req", 64'(m_wr_burst_req), 64'd1);
    check("t1_m_wr_len", 64'(m_wr_burst_len), 64'd128);
    check("t1_m_wr_addr", 64'(m_wr_burst_addr), 64'h0200_0000);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_grant_write", 64'(grant_write), 64'd1);
    check("t1_wr_data_route", m_wr_burst_data, 64'hC0C0_0000_0000_00A5);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 128; i++) begin
      m_wr_burst_data_req = 1;
      if (i == 60) c0_wr_burst_addr = 32'h0;
      #1;
      if (c0_wr_burst_data_req) cnt0++;
      if (c1_wr_burst_data_req || c1_wr_burst_finish) cnt1++;
      tick();
    end
    m_wr_burst_data_req = 0;
    check("t1_c0_data_req_cnt", 64'(cnt0), 64'd128);
    check("t1_c1_quiet", 64'(cnt1), 64'd0);
    check("t1_addr_held", 64'(m_wr_burst_addr), 64'h0200_0000);
    m_wr_burst_finish = 1;
    #1;
    check("t1_c0_finish", 64'(c0_wr_burst_finish), 64'd1);
    check("t1_c1_finish", 64'(c1_wr_burst_finish), 64'd0);
    tick();
    m_wr_burst_finish = 0; c0_wr_burst_req = 0;
    #1;
    check("t1_req_dropped", 64'(m_wr_burst_req), 64'd0);
    check("t1_release_busy", 64'(busy), 64'd1);
    check("t1_finish_one_cycle", 64'(c0_wr_burst_finish), 64'd0);
    tick();

    // ---- tie after reset: c0 first, then c1, then c0 again ----
    rst_n = 0; #1; rst_n = 1;
    c0_wr_burst_req = 1; c0_wr_burst_len = 10'd4; c0_wr_burst_addr = 32'h100;
    c1_wr_burst_req = 1; c1_wr_burst_len = 10'd4; c1_wr_burst_addr = 32'h200;
    tick();
    check("t2_first_client", 64'(grant_client), 64'd0);
    check("t2_first_addr", 64'(m_wr_burst_addr), 64'h100);
    m_wr_burst_finish = 1; #1;
    check("t2_c0_fin", 64'(c0_wr_burst_finish), 64'd1);
    check("t2_c1_no_fin", 64'(c1_wr_burst_finish), 64'd0);
    tick();  // T+1 RELEASE
    m_wr_burst_finish = 0; c0_wr_burst_req = 0; #1;
    check("t2_t1_no_req", 64'(m_wr_burst_req), 64'd0);
    tick();  // T+2 IDLE
    check("t2_t2_no_req", 64'(m_wr_burst_req), 64'd0);
    tick();  // T+3
    check("t2_t3_req", 64'(m_wr_burst_req), 64'd1);
    check("t2_second_client", 64'(grant_client), 64'd1);
    check("t2_second_addr", 64'(m_wr_burst_addr), 64'h200);
    check("t2_c1_data_route", m_wr_burst_data, 64'hC1C1_0000_0000_005A);
    m_wr_burst_data_req = 1; #1;
    check("t2_c1_data_req", 64'(c1_wr_burst_data_req), 64'd1);
    check("t2_c0_no_data_req", 64'(c0_wr_burst_data_req), 64'd0);
    m_wr_burst_data_req = 0;
    m_wr_burst_finish = 1; #1;
    check("t2_c1_fin", 64'(c1_wr_burst_finish), 64'd1);
    tick();  // RELEASE
    m_wr_burst_finish = 0; c1_wr_burst_req = 0;
    tick();  // IDLE: both request again
    c0_wr_burst_req = 1; c1_wr_burst_req = 1;
    tick();
    check("t2_alternate_client", 64'(grant_client), 64'd0);
    m_wr_burst_finish = 1; #1;
    tick();  // RELEASE
    m_wr_burst_finish = 0; c0_wr_burst_req = 0; c1_wr_burst_req = 0;

    // ---- c1 rd+wr together: write first, then read ----
    c1_rd_burst_req = 1; c1_rd_burst_len = 10'd8; c1_rd_burst_addr = 32'h300;
    c1_wr_burst_req = 1; c1_wr_burst_len = 10'd4; c1_wr_burst_addr = 32'h600;
    tick();  // IDLE
    tick();
    check("t3_wr_first", 64'(m_wr_burst_req), 64'd1);
    check("t3_rd_waits", 64'(m_rd_burst_req), 64'd0);
    check("t3_client", 64'(grant_client), 64'd1);
    m_wr_burst_finish = 1; #1;
    tick();  // RELEASE
    m_wr_burst_finish = 0; c1_wr_burst_req = 0;
    tick();  // IDLE
    tick();
    check("t3_rd_second", 64'(m_rd_burst_req), 64'd1);
    check("t3_rd_addr", 64'(m_rd_burst_addr), 64'h300);
    check("t3_rd_len", 64'(m_rd_burst_len), 64'd8);
    check("t3_grant_write", 64'(grant_write), 64'd0);
    m_rd_burst_data_valid = 1; m_rd_burst_data = 64'hDEAD_BEEF_1234_5678; #1;
    check("t3_c1_valid", 64'(c1_rd_burst_data_valid), 64'd1);
    check("t3_c0_no_valid", 64'(c0_rd_burst_data_valid), 64'd0);
    check("t3_broadcast", c0_rd_burst_data, 64'hDEAD_BEEF_1234_5678);
    m_rd_burst_data_valid = 0;
    m_wr_burst_finish = 1; #1;
    check("t3_wrong_dir_fin", 64'(c1_wr_burst_finish), 64'd0);
    tick();
    m_wr_burst_finish = 0; #1;
    check("t3_still_burst", 64'(m_rd_burst_req), 64'd1);
    m_rd_burst_finish = 1; #1;
    check("t3_c1_rd_fin", 64'(c1_rd_burst_finish), 64'd1);
    check("t3_c0_rd_no_fin", 64'(c0_rd_burst_finish), 64'd0);
    tick();  // RELEASE
    m_rd_burst_finish = 0; c1_rd_burst_req = 0;
    tick();  // IDLE
    check("t3_idle", 64'(busy), 64'd0);

    // ---- c0 read with len 0 ----
    c0_rd_burst_req = 1; c0_rd_burst_len = 10'd0; c0_rd_burst_addr = 32'h700;
    tick();  // ZERO
    check("t4_zero_fin", 64'(c0_rd_burst_finish), 64'd1);
    check("t4_no_m_req", 64'(m_rd_burst_req), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    c0_rd_burst_req = 0;
    tick();  // RELEASE
    check("t4_fin_done", 64'(c0_rd_burst_finish), 64'd0);
    check("t4_no_m_req2", 64'(m_rd_burst_req), 64'd0);
    tick();  // IDLE
    check("t4_idle", 64'(busy), 64'd0);

    // ---- reset during beat 50 of a read, pending c1 write served after ----
    c0_rd_burst_req = 1; c0_rd_burst_len = 10'd100; c0_rd_burst_addr = 32'h400;
    tick();
    check("t6_rd_req", 64'(m_rd_burst_req), 64'd1);
    c1_wr_burst_req = 1; c1_wr_burst_len = 10'd2; c1_wr_burst_addr = 32'h500;
    m_rd_burst_data_valid = 1;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 0; #1;
    check("t6_rst_rd_req", 64'(m_rd_burst_req), 64'd0);
    check("t6_rst_rd_addr", 64'(m_rd_burst_addr), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_valid", 64'(c0_rd_burst_data_valid), 64'd0);
    check("t6_rst_m_wr_req", 64'(m_wr_burst_req), 64'd0);
    tick();
    rst_n = 1; c0_rd_burst_req = 0; m_rd_burst_data_valid = 0;
    tick();
    check("t6_c1_granted", 64'(m_wr_burst_req), 64'd1);
    check("t6_c1_client", 64'(grant_client), 64'd1);
    check("t6_c1_addr", 64'(m_wr_burst_addr), 64'h500);
    m_wr_burst_finish = 1; #1;
    check("t6_c1_fin", 64'(c1_wr_burst_finish), 64'd1);
    tick();
    m_wr_burst_finish = 0; c1_wr_burst_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
